// File: rtl/ovl_fire_collector.sv
// Collects OVL checker fire bits into saturating per-checker counts, a first-failure record and an ack'd irq.
// Optional OVL_FIRE_XCHK_EN: X/Z fire bits count as fires and set a sticky x_seen flag.
module ovl_fire_collector #(
  parameter int NUM_CHK = 8,
  parameter int CNT_W   = 8,
  parameter int ID_W    = (NUM_CHK > 1) ? $clog2(NUM_CHK) : 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic [NUM_CHK-1:0] fire,
  input  logic               ack,
  input  logic [ID_W-1:0]    rd_sel,
  output logic [CNT_W-1:0]   rd_count,
  output logic               irq,
  output logic               first_valid,
  output logic [ID_W-1:0]    first_id,
  output logic [NUM_CHK-1:0] first_vec,
  output logic [15:0]        total_fires,
`ifdef OVL_FIRE_XCHK_EN
  output logic               x_seen,
`endif
  output logic [1:0]         dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PEND  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q [NUM_CHK];
  logic [CNT_W-1:0]     cnt_d [NUM_CHK];
  logic [15:0]          tot_q, tot_d;
  logic                 irq_q, irq_d;
  logic                 fv_q, fv_d;
  logic [ID_W-1:0]      fid_q, fid_d;
  logic [NUM_CHK-1:0]   fvec_q, fvec_d;
  logic [CNT_W-1:0]     rdc_q, rdc_d;
  logic [NUM_CHK-1:0]   f_raw;
  logic [NUM_CHK-1:0]   f_eff;
  logic                 any_fire;
  logic [ID_W-1:0]      low_id;
`ifdef OVL_FIRE_XCHK_EN
  logic                 x_det;
  logic                 xs_q, xs_d;
`endif

  // Unknown fire bits are folded to 1, matching OVL's treatment of X on test_expr.
  always_comb begin
    f_raw = fire;
`ifdef OVL_FIRE_XCHK_EN
    x_det = 1'b0;
    for (int i = 0; i < NUM_CHK; i++) begin
      f_raw[i] = (fire[i] !== 1'b0);
      if ((fire[i] === 1'bx) || (fire[i] === 1'bz)) x_det = 1'b1;
    end
    xs_d = xs_q | (x_det & enable);
`endif
    f_eff    = f_raw & {NUM_CHK{enable}};
    any_fire = |f_eff;
  end

  always_comb begin
    low_id = '0;
    for (int i = NUM_CHK - 1; i >= 0; i--) begin
      if (f_eff[i]) low_id = ID_W'(i);
    end
  end

  always_comb begin
    tot_d = tot_q;
    if (any_fire && (tot_q != 16'hFFFF)) tot_d = tot_q + 16'd1;
    for (int i = 0; i < NUM_CHK; i++) begin
      cnt_d[i] = cnt_q[i];
      if (f_eff[i] && (cnt_q[i] != {CNT_W{1'b1}})) cnt_d[i] = cnt_q[i] + 1'b1;
    end
    // Readout uses the post-increment value so it reflects fires landing on the same edge.
    rdc_d = '0;
    if (int'(rd_sel) < NUM_CHK) rdc_d = cnt_d[rd_sel];
  end

  always_comb begin
    state_d = state_q;
    irq_d   = irq_q;
    fv_d    = fv_q;
    fid_d   = fid_q;
    fvec_d  = fvec_q;
    case (state_q)
      IDLE: begin
        if (any_fire) begin
          fvec_d  = f_eff;
          fid_d   = low_id;
          fv_d    = 1'b1;
          irq_d   = 1'b1;
          state_d = PEND;
        end
      end
      PEND: begin
        if (ack) begin
          irq_d   = 1'b0;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        // Re-arm only after one quiet sample so a stuck checker cannot retrigger irq.
        if (!any_fire) begin
          fv_d    = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        irq_d   = 1'b0;
        fv_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      tot_q   <= '0;
      irq_q   <= 1'b0;
      fv_q    <= 1'b0;
      fid_q   <= '0;
      fvec_q  <= '0;
      rdc_q   <= '0;
      for (int i = 0; i < NUM_CHK; i++) cnt_q[i] <= '0;
`ifdef OVL_FIRE_XCHK_EN
      xs_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      tot_q   <= tot_d;
      irq_q   <= irq_d;
      fv_q    <= fv_d;
      fid_q   <= fid_d;
      fvec_q  <= fvec_d;
      rdc_q   <= rdc_d;
      for (int i = 0; i < NUM_CHK; i++) cnt_q[i] <= cnt_d[i];
`ifdef OVL_FIRE_XCHK_EN
      xs_q    <= xs_d;
`endif
    end
  end

  assign rd_count    = rdc_q;
  assign irq         = irq_q;
  assign first_valid = fv_q;
  assign first_id    = fid_q;
  assign first_vec   = fvec_q;
  assign total_fires = tot_q;
  assign dbg_state   = state_q;
`ifdef OVL_FIRE_XCHK_EN
  assign x_seen      = xs_q;
`endif

endmodule

// File: tb/tb_ovl_fire_collector.sv
// Directed bench for ovl_fire_collector (NUM_CHK=8, CNT_W=4) with hand-computed expectations.
module tb_ovl_fire_collector;

  localparam int NUM_CHK = 8;
  localparam int CNT_W   = 4;
  localparam int ID_W    = 3;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PEND  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic               clock = 1'b0;
  logic               reset;
  logic               enable;
  logic [NUM_CHK-1:0] fire;
  logic               ack;
  logic [ID_W-1:0]    rd_sel;
  logic [CNT_W-1:0]   rd_count;
  logic               irq;
  logic               first_valid;
  logic [ID_W-1:0]    first_id;
  logic [NUM_CHK-1:0] first_vec;
  logic [15:0]        total_fires;
  logic [1:0]         dbg_state;
`ifdef OVL_FIRE_XCHK_EN
  logic               x_seen;
`endif

  int tests = 0;
  int fails = 0;

  ovl_fire_collector #(.NUM_CHK(NUM_CHK), .CNT_W(CNT_W)) dut (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .fire        (fire),
    .ack         (ack),
    .rd_sel      (rd_sel),
    .rd_count    (rd_count),
    .irq         (irq),
    .first_valid (first_valid),
    .first_id    (first_id),
    .first_vec   (first_vec),
    .total_fires (total_fires),
`ifdef OVL_FIRE_XCHK_EN
    .x_seen      (x_seen),
`endif
    .dbg_state   (dbg_state)
  );

  always #5 clock = ~clock;

  // One rising edge, then settle so outputs are sampled away from the edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_irq"},   32'(irq), 32'd0);
    check({tag, "_fv"},    32'(first_valid), 32'd0);
    check({tag, "_fid"},   32'(first_id), 32'd0);
    check({tag, "_fvec"},  32'(first_vec), 32'd0);
    check({tag, "_tot"},   32'(total_fires), 32'd0);
    check({tag, "_rdc"},   32'(rd_count), 32'd0);
    check({tag, "_state"}, 32'(dbg_state), 32'(S_IDLE));
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; fire = '0; ack = 1'b0; rd_sel = '0;
    step(); step();
    reset = 1'b0;
    check_reset_state("reset");

    // Idle cycles, every counter reads zero.
    repeat (5) step();
    for (int i = 0; i < NUM_CHK; i++) begin
      rd_sel = ID_W'(i);
      step();
      check($sformatf("idle_rd%0d", i), 32'(rd_count), 32'd0);
    end
    check("idle_irq", 32'(irq), 32'd0);
    check("idle_tot", 32'(total_fires), 32'd0);

    // ack in IDLE is ignored.
    ack = 1'b1; step(); ack = 1'b0;
    check("ack_idle_state", 32'(dbg_state), 32'(S_IDLE));

    // First capture.
    fire = 8'h24; step(); fire = '0;
    check("cap_irq", 32'(irq), 32'd1);
    check("cap_fv", 32'(first_valid), 32'd1);
    check("cap_fid", 32'(first_id), 32'd2);
    check("cap_fvec", 32'(first_vec), 32'h24);
    check("cap_state", 32'(dbg_state), 32'(S_PEND));
    rd_sel = 3'd2; step();
    check("cap_rd2", 32'(rd_count), 32'd1);
    rd_sel = 3'd5; step();
    check("cap_rd5", 32'(rd_count), 32'd1);
    check("cap_tot", 32'(total_fires), 32'd1);

    // Later fires in PEND only count.
    rd_sel = 3'd0; fire = 8'h01;
    repeat (3) step();
    fire = '0;
    check("pend_rd0", 32'(rd_count), 32'd3);
    check("pend_fid", 32'(first_id), 32'd2);
    check("pend_irq", 32'(irq), 32'd1);
    check("pend_tot", 32'(total_fires), 32'd4);

    ack = 1'b1; step(); ack = 1'b0;
    check("ack_irq", 32'(irq), 32'd0);
    check("ack_fv", 32'(first_valid), 32'd1);
    check("ack_state", 32'(dbg_state), 32'(S_DRAIN));
    step();
    check("drain_fv", 32'(first_valid), 32'd0);
    check("drain_state", 32'(dbg_state), 32'(S_IDLE));

    fire = 8'h80; step(); fire = '0;
    check("rearm_irq", 32'(irq), 32'd1);
    check("rearm_fid", 32'(first_id), 32'd7);
    check("rearm_fvec", 32'(first_vec), 32'h80);

    // Stuck checker: fire[3] high across ack must not re-raise irq while draining.
    rd_sel = 3'd3; fire = 8'h08;
    step();
    ack = 1'b1; step(); ack = 1'b0;
    check("stuck_ack_irq", 32'(irq), 32'd0);
    for (int i = 0; i < 10; i++) begin
      step();
      check($sformatf("stuck_irq%0d", i), 32'(irq), 32'd0);
    end
    check("stuck_state", 32'(dbg_state), 32'(S_DRAIN));
    check("stuck_fv", 32'(first_valid), 32'd1);
    fire = '0; step();
    check("stuck_release", 32'(dbg_state), 32'(S_IDLE));
    fire = 8'h08; step(); fire = '0;
    check("stuck_reirq", 32'(irq), 32'd1);
    check("stuck_fid", 32'(first_id), 32'd3);
    check("stuck_rd3", 32'(rd_count), 32'd13);
    ack = 1'b1; step(); ack = 1'b0; step();

    // Saturation of a 4-bit counter.
    rd_sel = 3'd1; fire = 8'h02;
    repeat (20) step();
    fire = '0;
    check("sat_rd1", 32'(rd_count), 32'd15);
    check("sat_tot", 32'(total_fires), 32'd38);
    ack = 1'b1; step(); ack = 1'b0; step();
    check("sat_idle", 32'(dbg_state), 32'(S_IDLE));

    // enable=0 masks everything.
    enable = 1'b0; fire = 8'hFF;
    repeat (3) step();
    check("dis_irq", 32'(irq), 32'd0);
    check("dis_rd1", 32'(rd_count), 32'd15);
    check("dis_tot", 32'(total_fires), 32'd38);
    check("dis_state", 32'(dbg_state), 32'(S_IDLE));

    // enable=0 in DRAIN counts as quiet and re-arms.
    enable = 1'b1; fire = 8'h10; step();
    ack = 1'b1; step(); ack = 1'b0;
    check("dren_state", 32'(dbg_state), 32'(S_DRAIN));
    enable = 1'b0; step();
    check("dren_idle", 32'(dbg_state), 32'(S_IDLE));
    check("dren_fv", 32'(first_valid), 32'd0);
    enable = 1'b1; fire = '0;

`ifdef OVL_FIRE_XCHK_EN
    fire = 8'bxxx0_0000; fire[7:5] = 3'b000; fire[4] = 1'bx; step(); fire = '0;
    check("x_seen", 32'(x_seen), 32'd1);
    check("x_irq", 32'(irq), 32'd1);
    check("x_fid", 32'(first_id), 32'd4);
    rd_sel = 3'd4; step();
    check("x_rd4", 32'(rd_count), 32'd1);
`else
    fire = 8'h40; step(); fire = '0;
    check("pre_rst_irq", 32'(irq), 32'd1);
`endif

    // Reset wins over a simultaneous ack and fire.
    reset = 1'b1; ack = 1'b1; fire = 8'hFF; step();
    reset = 1'b0; ack = 1'b0; fire = '0; rd_sel = 3'd1;
    check_reset_state("rst2");
`ifdef OVL_FIRE_XCHK_EN
    check("rst2_xseen", 32'(x_seen), 32'd0);
`endif
    step();
    check("rst2_rd1", 32'(rd_count), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ovl_fire_collector.md
Name: ovl_fire_collector

Overview:
- Consumer end of the OVL checker fire interface: gathers the per-checker fire outputs from up to NUM_CHK OVL instances (ovl_always, etc.) and turns them into per-checker failure counts, a first-failure record and a level interrupt with acknowledge handshake.
- Sits beside the checker bank in simulation benches, or in an on-chip debug wrapper, so firmware or a UVM monitor reads one summary instead of polling every checker.

Parameters:
- NUM_CHK, 8, number of fire inputs (1..32).
- CNT_W, 8, width of each per-checker failure counter; counters saturate.
- ID_W, $clog2(NUM_CHK) (min 1), width of checker index fields.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  fire sampling enable; 0 = fire ignored (no counts, no capture).
- fire  input  NUM_CHK  one bit per checker, 1 = checker fired this cycle.
- ack  input  1  interrupt acknowledge, single-cycle pulse or level.
- rd_sel  input  ID_W  checker index for count readout.
- rd_count  output  CNT_W  registered count of checker rd_sel.
- irq  output  1  level interrupt, high while a failure is unacknowledged.
- first_valid  output  1  first_id/first_vec hold a captured failure.
- first_id  output  ID_W  lowest-index checker firing in the capture cycle.
- first_vec  output  NUM_CHK  full fire vector from the capture cycle.
- total_fires  output  16  saturating count of cycles with any fire.

Behaviour:
- All outputs registered. On reset: irq=0, first_valid=0, first_id=0, first_vec=0, total_fires=0, rd_count=0, all counters=0, state=IDLE.
- Reset mid-operation takes priority over every other event, including an ack or fire in the same cycle.
- Sampling: f_eff = fire & {NUM_CHK{enable}}, taken at each rising edge.
- Counters:
  - Each counter i increments by 1 when f_eff[i]=1, in every state.
  - A counter holds at 2^CNT_W-1 and never wraps.
  - total_fires increments when |f_eff, saturating at 16'hFFFF.
- rd_count: rd_count <= cnt[rd_sel], 1-cycle read latency. Its value reflects increments that complete on the same edge. rd_sel >= NUM_CHK returns 0.
- FSM, 3 states:
  - IDLE: if |f_eff, capture first_vec=f_eff, first_id=lowest set index, first_valid=1, irq=1, go to PEND. irq and first_valid are visible the cycle after fire is sampled (1-cycle latency).
  - PEND: irq held at 1; first_* frozen, and later fires only count. On ack=1: irq=0, go to DRAIN; first_valid stays 1 so software can still read the record.
  - DRAIN: wait until f_eff==0 for one sampled cycle, then first_valid=0 and go to IDLE. This stops a persistently firing checker from re-raising irq every cycle.
  - A fire in the same cycle as the DRAIN->IDLE transition is impossible by definition: the exit condition requires f_eff==0.
- ack outside PEND is ignored. ack and a new fire in the same PEND cycle: ack wins and the state goes to DRAIN; the fire is still counted.
- enable=0 in PEND does not drop irq. enable=0 in DRAIN counts as f_eff==0, so the block returns to IDLE.
- first_id priority: lowest index among simultaneously set bits.

Optional Feature:
- Macro OVL_FIRE_XCHK_EN.
- When defined:
  - Any fire bit that is X or Z (checked with a 4-state compare) is treated as 1 for counting and capture.
  - Sticky output port x_seen (1 bit, reset 0) is set and held until reset.
  - first_vec records such bits as 1.
  - This mirrors OVL behaviour, where an X on test_expr fires the checker.
- When not defined: no x_seen port; X bits propagate through the normal 2-state logic with no special handling.

Test Plan:
- Reset, then idle 5 cycles with fire=0 -> irq=0, first_valid=0, total_fires=0, rd_count=0 for every rd_sel.
- NUM_CHK=8, fire=8'b0010_0100 for 1 cycle -> next cycle irq=1, first_id=2, first_vec=8'h24. Then rd_sel=2 and rd_sel=5 each read 1, and total_fires=1.
- While in PEND, fire=8'h01 for 3 cycles -> first_id stays 2, cnt[0]=3, irq stays 1. Pulse ack -> irq=0 the next cycle. Then fire=0 -> first_valid=0 and the block re-arms. A new fire=8'h80 gives irq=1, first_id=7.
- fire[3] held at 1 across ack for 10 cycles -> irq does not re-assert while in DRAIN. After fire drops for 1 cycle, reasserting fire[3] raises irq again.
- CNT_W=4, fire[1]=1 for 20 cycles -> cnt[1] stops at 15. enable=0 with fire=8'hFF -> no count change, irq stays 0.
- With OVL_FIRE_XCHK_EN defined, fire[4]=1'bx for 1 cycle in IDLE -> x_seen=1, irq=1, first_id=4, cnt[4]=1. Assert reset with ack=1 in the same cycle -> all outputs return to reset values.
